// File: rtl/deconvolution.sv
// Recursive long-division inverse of the 8x8 linear convolution block: recovers x[n] from y and h.
// Optional tail residual check over y[N..2N-2] is built when DECONV_TAIL_CHECK_EN is defined.
module deconvolution #(
    parameter int unsigned N  = 8,
    parameter int unsigned XW = 4,
    parameter int unsigned HW = 4,
    parameter int unsigned YW = XW + HW + $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N*HW-1:0]   h_flat,
    input  logic              y_valid,
    output logic              y_ready,
    input  logic [YW-1:0]     y_data,
    output logic              x_valid,
    input  logic              x_ready,
    output logic [XW-1:0]     x_data,
    output logic              done,
    output logic              err
);

    localparam int unsigned RW = YW + 2;
    localparam int unsigned PW = HW + XW;
    localparam int unsigned KW = $clog2(N);
    localparam int unsigned CW = $clog2(2 * N);
    localparam int unsigned DW = (XW > 1) ? $clog2(XW) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StWaitY,
        StMac,
        StDiv,
        StOut,
        StTailMac,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [HW-1:0]        h_q    [N];
    logic [XW-1:0]        hist_q [N];
    logic [XW-1:0]        hist_d [N];
    logic [CW-1:0]        n_q, n_d;
    logic [CW-1:0]        k_q, k_d;
    logic [DW-1:0]        cnt_q, cnt_d;
    logic signed [RW-1:0] r_q, r_d;
    logic [XW-1:0]        q_q, q_d;
    logic                 err_q, err_d;

    logic [KW-1:0]        hidx, xidx;
    logic [PW-1:0]        prod;
    logic signed [RW-1:0] r_sub, trial, rem_next;
    logic                 div_take;

    // n_q doubles as the tail sample index m once all x have been emitted
    assign hidx     = k_q[KW-1:0];
    assign xidx     = KW'(n_q - k_q);
    assign prod     = h_q[hidx] * hist_q[xidx];
    assign r_sub    = r_q - $signed({{(RW - PW){1'b0}}, prod});
    assign trial    = $signed({{(RW - HW){1'b0}}, h_q[0]} << cnt_q);
    assign div_take = (r_q >= trial);
    assign rem_next = div_take ? (r_q - trial) : r_q;

    assign err = err_q;

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        n_d     = n_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        err_d   = err_q;
        y_ready = 1'b0;
        x_valid = 1'b0;
        x_data  = '0;
        done    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    err_d = 1'b0;
                    n_d   = '0;
                    for (int i = 0; i < N; i++) begin
                        hist_d[i] = '0;
                    end
                    if (h_flat[HW-1:0] == '0) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StWaitY;
                    end
                end
            end

            StWaitY: begin
                y_ready = 1'b1;
                if (y_valid) begin
                    r_d = $signed({2'b00, y_data});
                    if (n_q == '0) begin
                        cnt_d   = DW'(XW - 1);
                        q_d     = '0;
                        state_d = StDiv;
                    end else begin
                        k_d     = CW'(1);
                        state_d = StMac;
                    end
`ifdef DECONV_TAIL_CHECK_EN
                    if (n_q >= CW'(N)) begin
                        k_d     = n_q - CW'(N - 1);
                        state_d = StTailMac;
                    end
`endif
                end
            end

            StMac: begin
                r_d = r_sub;
                if (k_q == n_q) begin
                    cnt_d   = DW'(XW - 1);
                    q_d     = '0;
                    state_d = StDiv;
                end else begin
                    k_d = k_q + CW'(1);
                end
            end

            // Restoring division: a negative or oversized r leaves a nonzero remainder,
            // so the floor/saturation error cases all reduce to the remainder test.
            StDiv: begin
                r_d = rem_next;
                if (div_take) begin
                    q_d[cnt_q] = 1'b1;
                end
                if (cnt_q == '0) begin
                    err_d   = err_q | (rem_next != '0);
                    state_d = StOut;
                end else begin
                    cnt_d = cnt_q - DW'(1);
                end
            end

            StOut: begin
                x_valid = 1'b1;
                x_data  = q_q;
                if (x_ready) begin
                    hist_d[n_q[KW-1:0]] = q_q;
                    n_d = n_q + CW'(1);
                    if (n_q == CW'(N - 1)) begin
`ifdef DECONV_TAIL_CHECK_EN
                        state_d = StWaitY;
`else
                        state_d = StDone;
`endif
                    end else begin
                        state_d = StWaitY;
                    end
                end
            end

`ifdef DECONV_TAIL_CHECK_EN
            StTailMac: begin
                r_d = r_sub;
                if (k_q == CW'(N - 1)) begin
                    err_d = err_q | (r_sub != '0);
                    n_d   = n_q + CW'(1);
                    if (n_q == CW'(2 * N - 2)) begin
                        state_d = StDone;
                    end else begin
                        state_d = StWaitY;
                    end
                end else begin
                    k_d = k_q + CW'(1);
                end
            end
`endif

            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            n_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                h_q[i]    <= '0;
                hist_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            err_q   <= err_d;
            hist_q  <= hist_d;
            if (state_q == StIdle && start) begin
                for (int i = 0; i < N; i++) begin
                    h_q[i] <= h_flat[i*HW +: HW];
                end
            end
        end
    end

endmodule

// File: tb/tb_deconvolution.sv
// Self-checking bench for deconvolution: directed vector table, reset/abort sequences and
// randomized frames against an arithmetic reference model.
module tb_deconvolution;

    localparam int N  = 8;
    localparam int XW = 4;
    localparam int HW = 4;
    localparam int YW = 11;
    localparam int NY = 2 * N - 1;
`ifdef DECONV_TAIL_CHECK_EN
    localparam int EXPY = NY;
`else
    localparam int EXPY = N;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [N*HW-1:0] h_flat = '0;
    logic            y_valid = 1'b0;
    logic            y_ready;
    logic [YW-1:0]   y_data = '0;
    logic            x_valid;
    logic            x_ready = 1'b0;
    logic [XW-1:0]   x_data;
    logic            done;
    logic            err;

    deconvolution dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .h_flat (h_flat),
        .y_valid(y_valid),
        .y_ready(y_ready),
        .y_data (y_data),
        .x_valid(x_valid),
        .x_ready(x_ready),
        .x_data (x_data),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N*HW-1:0]  h;
        logic [NY*YW-1:0] y;
        logic [N*XW-1:0]  x;
        logic             e;
        logic [3:0]       hold_at;
        logic [3:0]       hold_len;
    } vec_t;

    vec_t tbl [4];

    int   n_checks = 0;
    int   n_fail = 0;
    int   yv [NY];
    int   exp_x [N];
    logic exp_e;
    int   got_x [$];
    int   lat [$];
    int   done_cnt, y_taken;
    logic err_at_done, first_yr, first_done;
    bit   err_drop, hold_bad, yr_seen, timed_out, aborted;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: x[n] = (y[n] - sum h[k] x[n-k]) / h0, floored, clamped to [0, 2^XW-1].
    function automatic void model(input logic [N*HW-1:0] hf);
        int h [N];
        int acc;
        exp_e = 1'b0;
        for (int k = 0; k < N; k++) h[k] = int'(hf[k*HW +: HW]);
        for (int n = 0; n < N; n++) exp_x[n] = 0;
        if (h[0] == 0) begin
            exp_e = 1'b1;
            return;
        end
        for (int n = 0; n < N; n++) begin
            acc = yv[n];
            for (int k = 1; k <= n; k++) acc -= h[k] * exp_x[n - k];
            if (acc < 0) begin
                exp_x[n] = 0;
                exp_e = 1'b1;
            end else if (acc / h[0] > (1 << XW) - 1) begin
                exp_x[n] = (1 << XW) - 1;
                exp_e = 1'b1;
            end else begin
                exp_x[n] = acc / h[0];
                if (acc % h[0] != 0) exp_e = 1'b1;
            end
        end
`ifdef DECONV_TAIL_CHECK_EN
        for (int m = N; m < NY; m++) begin
            acc = yv[m];
            for (int k = m - N + 1; k < N; k++) acc -= h[k] * exp_x[m - k];
            if (acc != 0) exp_e = 1'b1;
        end
`endif
    endfunction

    task automatic run_frame(input logic [N*HW-1:0] hf, input int hold_at, input int hold_len,
                             input int abort_after);
        int   cyc = 0;
        int   held = 0;
        int   hs_cyc = 0;
        int   post = -1;
        bit   seen_err = 0;
        bit   xv_prev = 0;
        bit   hy, hx;
        logic [XW-1:0] held_val = '0;
        got_x.delete();
        lat.delete();
        done_cnt = 0; y_taken = 0; err_at_done = 1'b0;
        err_drop = 0; hold_bad = 0; yr_seen = 0; timed_out = 0; aborted = 0;
        h_flat = hf;
        start = 1'b1;
        y_valid = 1'b0;
        x_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        first_yr = y_ready;
        first_done = done;
        while (cyc < 3000 && post != 0) begin
            if (y_ready) yr_seen = 1;
            if (err) seen_err = 1;
            else if (seen_err) err_drop = 1;
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    err_at_done = err;
                    post = 3;
                end
            end
            if (x_valid && !xv_prev) lat.push_back(cyc - hs_cyc);
            y_valid = (y_taken < NY);
            if (y_taken < NY) y_data = YW'(yv[y_taken]);
            else y_data = '0;
            x_ready = !(got_x.size() == hold_at && held < hold_len);
            if (got_x.size() == hold_at && held > 0 && held < hold_len && !x_valid) hold_bad = 1;
            if (x_valid && !x_ready) begin
                if (held == 0) held_val = x_data;
                else if (x_data !== held_val) hold_bad = 1;
                held++;
            end
            hy = y_valid && y_ready;
            hx = x_valid && x_ready;
            if (hx && held > 0 && got_x.size() == hold_at && x_data !== held_val) hold_bad = 1;
            if (hy) begin
                y_taken++;
                hs_cyc = cyc;
            end
            if (hx) got_x.push_back(int'(x_data));
            xv_prev = x_valid;
            @(posedge clk); #1;
            cyc++;
            if (post > 0) post--;
            if (abort_after >= 0 && hx && got_x.size() == abort_after) begin
                y_valid = 1'b0;
                x_ready = 1'b0;
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                aborted = 1;
                break;
            end
        end
        timed_out = !aborted && (post != 0);
        y_valid = 1'b0;
        x_ready = 1'b0;
    endtask

    task automatic check_frame(input string nm, input bit hzero);
        int lat_bad = 0;
        check({nm, ".timeout"}, timed_out, 0);
        check({nm, ".done_pulses"}, done_cnt, 1);
        check({nm, ".err"}, err_at_done, exp_e);
        check({nm, ".err_sticky"}, err_drop, 0);
        if (hzero) begin
            check({nm, ".done_after_start"}, first_done, 1);
            check({nm, ".y_ready_seen"}, yr_seen, 0);
            check({nm, ".x_count"}, got_x.size(), 0);
        end else begin
            check({nm, ".y_ready_after_start"}, first_yr, 1);
            check({nm, ".y_consumed"}, y_taken, EXPY);
            check({nm, ".x_count"}, got_x.size(), N);
            for (int n = 0; n < N && n < got_x.size(); n++)
                check($sformatf("%s.x[%0d]", nm, n), got_x[n], exp_x[n]);
            for (int i = 0; i < N && i < lat.size(); i++)
                if (lat[i] != i + XW + 1) lat_bad++;
            check({nm, ".latency"}, (lat.size() == N) ? lat_bad : 99, 0);
        end
    endtask

    task automatic load_vec(input int i);
        for (int m = 0; m < NY; m++) yv[m] = int'(tbl[i].y[m*YW +: YW]);
        for (int n = 0; n < N; n++) exp_x[n] = int'(tbl[i].x[n*XW +: XW]);
        exp_e = tbl[i].e;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '0;
        tbl[0].h = 32'h1111_1111;
        tbl[0].x = 32'h1111_1111;
        tbl[0].hold_at = 4'hF;
        tbl[1] = '0;
        tbl[1].h = 32'h9876_5432;
        tbl[1].x = 32'h0000_0001;
        tbl[1].hold_at = 4'd2;
        tbl[1].hold_len = 4'd5;
        tbl[2] = '0;
        tbl[2].h = 32'hFFFF_FFFF;
        tbl[2].x = 32'hFFFF_FFFF;
        tbl[2].hold_at = 4'hF;
        for (int m = 0; m < NY; m++) begin
            tbl[0].y[m*YW +: YW] = YW'((m < N) ? m + 1 : NY - m);
            tbl[1].y[m*YW +: YW] = YW'((m < N) ? m + 2 : 0);
            tbl[2].y[m*YW +: YW] = YW'(225 * ((m < N) ? m + 1 : NY - m));
        end
        tbl[3] = tbl[1];
        tbl[3].y[0 +: YW] = YW'(3);
        tbl[3].e = 1'b1;
        tbl[3].hold_at = 4'hF;
        tbl[3].hold_len = 4'd0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset.y_ready", y_ready, 0);
        check("reset.x_valid", x_valid, 0);
        check("reset.x_data", x_data, 0);
        check("reset.done", done, 0);
        check("reset.err", err, 0);

        for (int i = 0; i < 4; i++) begin
            load_vec(i);
            run_frame(tbl[i].h, int'(tbl[i].hold_at), int'(tbl[i].hold_len), -1);
            check_frame($sformatf("vec%0d", i), 0);
            if (tbl[i].hold_len != 0) check($sformatf("vec%0d.hold_stable", i), hold_bad, 0);
        end

        // h[0] == 0: immediate error and done, nothing consumed
        exp_e = 1'b1;
        run_frame(32'h1111_1110, 99, 0, -1);
        check_frame("h0_zero", 1);

        // Reset after the 3rd x handshake of an erroring frame, then a clean rerun
        load_vec(3);
        run_frame(tbl[3].h, 99, 0, 3);
        check("abort.reached", aborted, 1);
        check("abort.y_ready", y_ready, 0);
        check("abort.x_valid", x_valid, 0);
        check("abort.x_data", x_data, 0);
        check("abort.done", done, 0);
        check("abort.err", err, 0);
        @(posedge clk); #1;
        check("abort.idle_y_ready", y_ready, 0);
        load_vec(0);
        run_frame(tbl[0].h, 99, 0, -1);
        check_frame("after_reset", 0);

        for (int f = 0; f < 25; f++) begin
            logic [N*HW-1:0] hf;
            int hh [N];
            int xr [N];
            int s;
            for (int k = 0; k < N; k++) begin
                hh[k] = int'($urandom_range(0, 15));
                if (k == 0 && f % 8 != 7) hh[0] = int'($urandom_range(1, 15));
                hf[k*HW +: HW] = HW'(hh[k]);
                xr[k] = int'($urandom_range(0, 15));
            end
            for (int m = 0; m < NY; m++) begin
                s = 0;
                for (int k = 0; k < N; k++)
                    if (m - k >= 0 && m - k < N) s += hh[k] * xr[m - k];
                yv[m] = s;
            end
            if (f % 3 == 1) yv[$urandom_range(0, NY - 1)] = int'($urandom_range(0, 2047));
            if (f % 5 == 2) yv[$urandom_range(0, N - 1)] = int'($urandom_range(0, 40));
            model(hf);
            run_frame(hf, (f % 4 == 0) ? int'($urandom_range(0, N - 1)) : 99, 3, -1);
            check_frame($sformatf("rand%0d", f), hh[0] == 0);
            if (f % 4 == 0 && hh[0] != 0) check($sformatf("rand%0d.hold_stable", f), hold_bad, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
